// File: rtl/alarm_controller_pkg.sv
// Shared state encodings and time-field widths for the alarm controller slice.
`default_nettype none

package alarm_controller_pkg;

  localparam int HR_W  = 5;
  localparam int MIN_W = 6;
  localparam int SEC_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RINGING = 2'b01,
    ST_SNOOZE  = 2'b10
  } state_e;

endpackage

`default_nettype wire

// File: rtl/alarm_controller_tick_timer.sv
// tick_timer: counts tick pulses from zero and flags the tick that completes 'terminal' counts.
`default_nettype none

module tick_timer #(
  parameter int TW = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          tick,
  input  logic [TW-1:0] terminal,
  output logic          done
);

  logic [TW-1:0] cnt_q;
  logic [TW-1:0] cnt_d;

  assign done = tick & (cnt_q == (terminal - TW'(1)));

  // The owner clears the timer on the done tick, so it never reaches terminal.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (tick && !done) begin
      cnt_d = cnt_q + TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/alarm_controller.sv
// alarm_controller: alarm-time match detection plus the ring/snooze/stop state machine
// driving the buzzer and status outputs, all timing qualified by the 1 Hz tick.
`default_nettype none

module alarm_controller
  import alarm_controller_pkg::*;
#(
  parameter int RING_SECONDS   = 60,
  parameter int SNOOZE_SECONDS = 300,
  parameter int MAX_SNOOZES    = 3,
  parameter int TW             = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_1hz,
  input  logic [HR_W-1:0]  cur_hr,
  input  logic [MIN_W-1:0] cur_min,
  input  logic [SEC_W-1:0] cur_sec,
  input  logic [HR_W-1:0]  alarm_hr,
  input  logic [MIN_W-1:0] alarm_min,
  input  logic             alarm_en,
  input  logic             stop_p,
  input  logic             snooze_p,
  output logic [1:0]       state,
  output logic             ringing,
  output logic             buzzer,
  output logic [1:0]       snooze_cnt,
  output logic             missed
);

  localparam logic [TW-1:0] RING_T   = TW'(RING_SECONDS);
  localparam logic [TW-1:0] SNOOZE_T = TW'(SNOOZE_SECONDS);
  localparam logic [1:0]    MAX_SNZ  = 2'(MAX_SNOOZES);

  state_e     state_q, state_d;
  logic [1:0] snooze_cnt_q, snooze_cnt_d;
  logic       missed_q, missed_d;
  logic       beep_q, beep_d;
  logic       match_q;

  logic match;
  logic trigger;
  logic ring_tick, ring_clr, ring_done;
  logic snz_tick, snz_clr, snz_done;

  assign match   = alarm_en & (cur_hr == alarm_hr) & (cur_min == alarm_min) & (cur_sec == '0);
  assign trigger = match & ~match_q;

  // Timers run only in their own state and restart whenever that state is entered or left.
  assign ring_tick = tick_1hz & (state_q == ST_RINGING);
  assign ring_clr  = (state_q != ST_RINGING) | (state_d != ST_RINGING);
  assign snz_tick  = tick_1hz & (state_q == ST_SNOOZE);
  assign snz_clr   = (state_q != ST_SNOOZE) | (state_d != ST_SNOOZE);

  tick_timer #(.TW(TW)) u_ring_timer (
    .clk      (clk),
    .rst      (rst),
    .clr      (ring_clr),
    .tick     (ring_tick),
    .terminal (RING_T),
    .done     (ring_done)
  );

  tick_timer #(.TW(TW)) u_snooze_timer (
    .clk      (clk),
    .rst      (rst),
    .clr      (snz_clr),
    .tick     (snz_tick),
    .terminal (SNOOZE_T),
    .done     (snz_done)
  );

  always_comb begin
    state_d      = state_q;
    snooze_cnt_d = snooze_cnt_q;
    missed_d     = missed_q;
    beep_d       = beep_q;

    if (!alarm_en) begin
      state_d = ST_IDLE;
    end else if (stop_p) begin
      state_d  = ST_IDLE;
      missed_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (trigger) begin
            state_d = ST_RINGING;
            beep_d  = 1'b1;
          end
        end
        ST_RINGING: begin
          // A snooze beyond the limit falls through to normal tick handling.
          if (snooze_p && (snooze_cnt_q < MAX_SNZ)) begin
            state_d      = ST_SNOOZE;
            snooze_cnt_d = snooze_cnt_q + 2'd1;
          end else if (ring_done) begin
            state_d  = ST_IDLE;
            missed_d = 1'b1;
          end else if (tick_1hz) begin
            beep_d = ~beep_q;
          end
        end
        ST_SNOOZE: begin
          if (snz_done) begin
            state_d = ST_RINGING;
            beep_d  = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (state_d == ST_IDLE) begin
      snooze_cnt_d = '0;
      beep_d       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      snooze_cnt_q <= '0;
      missed_q     <= 1'b0;
      beep_q       <= 1'b0;
      match_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      snooze_cnt_q <= snooze_cnt_d;
      missed_q     <= missed_d;
      beep_q       <= beep_d;
      match_q      <= match;
    end
  end

  assign state      = state_q;
  assign ringing    = (state_q == ST_RINGING);
  assign buzzer     = beep_q & (state_q == ST_RINGING);
  assign snooze_cnt = snooze_cnt_q;
  assign missed     = missed_q;

endmodule

`default_nettype wire

// File: tb/tb_alarm_controller.sv
// Testbench for alarm_controller: directed scenarios plus randomized traffic against a reference model.
`default_nettype none

module tb_alarm_controller;

  localparam int RS = 4;
  localparam int SS = 3;
  localparam int MS = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick_1hz = 1'b0;
  logic       stop_p = 1'b0;
  logic       snooze_p = 1'b0;
  logic       alarm_en = 1'b0;
  logic [4:0] cur_hr = 5'd0;
  logic [5:0] cur_min = 6'd0;
  logic [5:0] cur_sec = 6'd0;
  logic [4:0] alarm_hr = 5'd7;
  logic [5:0] alarm_min = 6'd30;

  logic [1:0] state;
  logic       ringing;
  logic       buzzer;
  logic [1:0] snooze_cnt;
  logic       missed;

  alarm_controller #(
    .RING_SECONDS   (RS),
    .SNOOZE_SECONDS (SS),
    .MAX_SNOOZES    (MS),
    .TW             (9)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tick_1hz   (tick_1hz),
    .cur_hr     (cur_hr),
    .cur_min    (cur_min),
    .cur_sec    (cur_sec),
    .alarm_hr   (alarm_hr),
    .alarm_min  (alarm_min),
    .alarm_en   (alarm_en),
    .stop_p     (stop_p),
    .snooze_p   (snooze_p),
    .state      (state),
    .ringing    (ringing),
    .buzzer     (buzzer),
    .snooze_cnt (snooze_cnt),
    .missed     (missed)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: mode 0 idle, 1 ringing, 2 snoozing; elapsed counts whole seconds in the mode.
  int m_mode = 0;
  int m_elapsed = 0;
  int m_snoozes = 0;
  bit m_beep = 0;
  bit m_missed = 0;
  bit m_prev = 0;

  logic [6:0] obs;
  assign obs = {state, ringing, buzzer, snooze_cnt, missed};

  function automatic logic [6:0] exp_vec();
    logic [1:0] s;
    logic [1:0] n;
    s = 2'(m_mode);
    n = 2'(m_snoozes);
    return {s, (m_mode == 1), (m_beep && m_mode == 1), n, m_missed};
  endfunction

  task automatic model_update();
    bit match;
    match = alarm_en && (cur_hr == alarm_hr) && (cur_min == alarm_min) && (cur_sec == 0);
    if (!rst) begin
      m_mode = 0; m_elapsed = 0; m_snoozes = 0; m_beep = 0; m_missed = 0; m_prev = 0;
    end else begin
      if (!alarm_en) begin
        m_mode = 0;
      end else if (stop_p) begin
        m_mode = 0;
        m_missed = 0;
      end else if (m_mode == 1) begin
        if (snooze_p && m_snoozes < MS) begin
          m_mode = 2; m_snoozes++; m_elapsed = 0;
        end else if (tick_1hz) begin
          m_elapsed++;
          if (m_elapsed == RS) begin
            m_mode = 0; m_missed = 1;
          end else begin
            m_beep = !m_beep;
          end
        end
      end else if (m_mode == 2) begin
        if (tick_1hz) begin
          m_elapsed++;
          if (m_elapsed == SS) begin
            m_mode = 1; m_elapsed = 0; m_beep = 1;
          end
        end
      end else if (match && !m_prev) begin
        m_mode = 1; m_elapsed = 0; m_beep = 1;
      end
      if (m_mode == 0) begin
        m_snoozes = 0; m_elapsed = 0;
      end
      m_prev = match;
    end
  endtask

  task automatic cyc(input logic tk, input logic stp, input logic snz);
    tick_1hz = tk;
    stop_p   = stp;
    snooze_p = snz;
    @(posedge clk);
    model_update();
    #1;
    tick_1hz = 1'b0;
    stop_p   = 1'b0;
    snooze_p = 1'b0;
  endtask

  task automatic set_time(input int h, input int m, input int s);
    cur_hr  = 5'(h);
    cur_min = 6'(m);
    cur_sec = 6'(s);
  endtask

  task automatic arm_and_ring();
    set_time(7, 29, 59);
    cyc(0, 0, 0);
    set_time(7, 30, 0);
    cyc(0, 0, 0);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    checks++;
    if (obs !== 7'b0) begin
      errors++; $display("FAIL reset_state got %b exp %b", obs, 7'b0);
    end
    rst = 1'b1;
    alarm_en = 1'b1;
    cyc(0, 0, 0);
  endtask

  task automatic test_trigger();
    set_time(7, 29, 59);
    cyc(0, 0, 0);
    checks++;
    if (ringing !== 1'b0) begin
      errors++; $display("FAIL pre_match_ringing got %b exp 0", ringing);
    end
    set_time(7, 30, 0);
    cyc(0, 0, 0);
    checks++;
    if (obs !== 7'b01_1_1_00_0) begin
      errors++; $display("FAIL trigger_ring got %b exp %b", obs, 7'b01_1_1_00_0);
    end
    for (int i = 0; i < 2; i++) begin
      cyc(1, 0, 0);
      checks++;
      if (buzzer !== ((i == 0) ? 1'b0 : 1'b1) || obs !== exp_vec()) begin
        errors++; $display("FAIL buzzer_toggle_%0d got %b exp %b", i, obs, exp_vec());
      end
    end
  endtask

  task automatic test_timeout();
    cyc(0, 1, 0);
    arm_and_ring();
    for (int i = 1; i <= RS; i++) begin
      cyc(1, 0, 0);
      checks++;
      if (obs !== exp_vec() || state !== ((i == RS) ? 2'b00 : 2'b01) || missed !== (i == RS)) begin
        errors++; $display("FAIL timeout_tick_%0d got %b exp %b", i, obs, exp_vec());
      end
    end
    cyc(0, 1, 0);
    checks++;
    if (missed !== 1'b0 || obs !== exp_vec()) begin
      errors++; $display("FAIL stop_clears_missed got %b exp %b", obs, exp_vec());
    end
  endtask

  task automatic test_snooze();
    arm_and_ring();
    for (int r = 1; r <= MS; r++) begin
      cyc(0, 0, 1);
      checks++;
      if (obs !== {2'b10, 1'b0, 1'b0, 2'(r), 1'b0} || obs !== exp_vec()) begin
        errors++; $display("FAIL snooze_%0d got %b exp %b", r, obs, exp_vec());
      end
      for (int t = 1; t <= SS; t++) cyc(1, 0, 0);
      checks++;
      if (obs !== {2'b01, 1'b1, 1'b1, 2'(r), 1'b0} || obs !== exp_vec()) begin
        errors++; $display("FAIL re_ring_%0d got %b exp %b", r, obs, exp_vec());
      end
    end
    cyc(0, 0, 1);
    checks++;
    if (state !== 2'b01 || snooze_cnt !== 2'(MS) || obs !== exp_vec()) begin
      errors++; $display("FAIL snooze_limit got %b exp %b", obs, exp_vec());
    end
  endtask

  task automatic test_stop_snooze_same();
    cyc(0, 1, 1);
    checks++;
    if (obs !== 7'b00_0_0_00_0 || obs !== exp_vec()) begin
      errors++; $display("FAIL stop_wins got %b exp %b", obs, 7'b0);
    end
    for (int i = 0; i < 5; i++) cyc(0, 0, 0);
    checks++;
    if (state !== 2'b00 || obs !== exp_vec()) begin
      errors++; $display("FAIL no_retrigger got %b exp %b", obs, exp_vec());
    end
  endtask

  task automatic test_alarm_en_drop();
    arm_and_ring();
    cyc(0, 0, 1);
    checks++;
    if (state !== 2'b10) begin
      errors++; $display("FAIL en_pre_snooze got %b exp 10", state);
    end
    alarm_en = 1'b0;
    cyc(0, 0, 0);
    checks++;
    if (state !== 2'b00 || snooze_cnt !== 2'b00 || obs !== exp_vec()) begin
      errors++; $display("FAIL en_drop_idle got %b exp %b", obs, exp_vec());
    end
    alarm_en = 1'b1;
    cyc(0, 0, 0);
    checks++;
    if (ringing !== 1'b1 || obs !== exp_vec()) begin
      errors++; $display("FAIL en_reraise_trigger got %b exp %b", obs, exp_vec());
    end
  endtask

  task automatic test_reset_mid_ring();
    for (int i = 0; i < RS; i++) cyc(1, 0, 0);
    arm_and_ring();
    cyc(0, 0, 1);
    for (int t = 0; t < SS; t++) cyc(1, 0, 0);
    checks++;
    if (obs !== 7'b01_1_1_01_1 || obs !== exp_vec()) begin
      errors++; $display("FAIL pre_reset_state got %b exp %b", obs, 7'b01_1_1_01_1);
    end
    rst = 1'b0;
    cyc(0, 0, 0);
    checks++;
    if (obs !== 7'b0 || obs !== exp_vec()) begin
      errors++; $display("FAIL reset_mid_ring got %b exp %b", obs, 7'b0);
    end
    rst = 1'b1;
    cyc(0, 0, 0);
  endtask

  task automatic test_random();
    int r;
    for (int i = 0; i < 1500; i++) begin
      rst      = ($urandom_range(0, 199) != 0);
      alarm_en = ($urandom_range(0, 39) != 0);
      if ($urandom_range(0, 4) == 0) begin
        r = $urandom_range(0, 9);
        if (r < 4)       set_time(7, 29, 59);
        else if (r < 8)  set_time(7, 30, 0);
        else if (r == 8) set_time(7, 30, 1);
        else             set_time(8, 30, 0);
      end
      cyc(($urandom_range(0, 9) < 4), ($urandom_range(0, 39) == 0), ($urandom_range(0, 11) == 0));
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL rand_%0d got %b exp %b", i, obs, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_trigger();
    test_timeout();
    test_snooze();
    test_stop_snooze_same();
    test_alarm_en_drop();
    test_reset_mid_ring();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
